noc_local_packetizer: RTL and testbench

Local-port injection endpoint that segments messages into wormhole flits and drives them into the router's local input through a `Noc_flit_interface` sender binding. It is the transmit end of the flit protocol that the position mux routes between mesh neighbours. It accepts one command (destination plus length) and a payload word stream. It emits a head flit, then body flits, then a tail flit, under valid/ready flow control.

---
 rtl/noc_local_packetizer_pkg.sv | 35 +++
 rtl/noc_flit_out_reg.sv | 35 +++
 rtl/noc_local_packetizer.sv | 187 ++++++++++++++++++
 tb/tb_noc_local_packetizer.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_local_packetizer_pkg.sv
// Noc_parameters: shared types for the local-port packetizer.
//   flit_type_e   - 2-bit flit type carried in the top bits of every flit
//   pkt_state_e   - packetizer FSM states
//   head_fields_t - head/SINGLE field layout for the default mesh sizing
//                   (COORD_W = 4, MAX_LEN = 16); it sits directly below the
//                   type field
//   len_width()   - width of a length field able to hold 0..max_len
package Noc_parameters;

  typedef enum logic [1:0] {
    FLIT_HEAD   = 2'b00,
    FLIT_BODY   = 2'b01,
    FLIT_TAIL   = 2'b10,
    FLIT_SINGLE = 2'b11
  } flit_type_e;

  typedef enum logic [1:0] {
    PKT_IDLE,
    PKT_HEAD,
    PKT_BODY
  } pkt_state_e;

  typedef struct packed {
    logic [3:0] dst_x;
    logic [3:0] dst_y;
    logic [3:0] src_x;
    logic [3:0] src_y;
    logic [4:0] len;
  } head_fields_t;

  function automatic int len_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/noc_flit_out_reg.sv
// noc_flit_out_reg: single-entry valid/ready output register.
//   clk, rst           - clock, synchronous active-high reset
//   load, load_flit    - write a new flit; only legal while slot_free = 1
//   out_valid/out_flit - registered flit toward the router local input
//   out_ready          - downstream accept
//   slot_free          - register is empty or drains this cycle
// The flit is held stable for as long as out_valid = 1 and out_ready = 0.
module noc_flit_out_reg #(
  parameter int FLIT_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [FLIT_W-1:0] load_flit,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [FLIT_W-1:0] out_flit,
  output logic              slot_free
);

  assign slot_free = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_flit  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_flit  <= load_flit;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/noc_local_packetizer.sv
// noc_local_packetizer: local-port injection endpoint. Segments one command
// (destination + length) plus a payload word stream into a wormhole packet:
// HEAD, BODY..., TAIL (or a single SINGLE flit for a zero-length packet).
//   noc_clk, noc_rst      - clock, synchronous active-high reset
//   cmd_valid/cmd_ready   - command handshake; cmd_dst_x, cmd_dst_y, cmd_len
//   data_valid/data_ready - payload handshake; data_word (FLIT_W-2 bits)
//   out_valid/out_ready   - flit handshake toward the router; out_flit
//   err_len               - one-cycle pulse after accepting an over-long command
//   pkt_count, flit_count - statistics, only when NOC_PKT_STATS_EN is defined
// Optional feature macro: NOC_PKT_STATS_EN.
module noc_local_packetizer
  import Noc_parameters::*;
#(
  parameter int FLIT_W  = 64,
  parameter int COORD_W = 4,
  parameter int MAX_LEN = 16,
  parameter int SRC_X   = 0,
  parameter int SRC_Y   = 0,
  localparam int LEN_W  = len_width(MAX_LEN)
) (
  input  logic               noc_clk,
  input  logic               noc_rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [COORD_W-1:0] cmd_dst_x,
  input  logic [COORD_W-1:0] cmd_dst_y,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic               data_valid,
  output logic               data_ready,
  input  logic [FLIT_W-3:0]  data_word,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [FLIT_W-1:0]  out_flit,
  output logic               err_len
`ifdef NOC_PKT_STATS_EN
  ,
  output logic [31:0]        pkt_count,
  output logic [31:0]        flit_count
`endif
);

  localparam int HEAD_BITS = 2 + 4 * COORD_W + LEN_W;
  localparam int PAD_W     = FLIT_W - HEAD_BITS;
  localparam logic [COORD_W-1:0] SRC_X_C   = COORD_W'(SRC_X);
  localparam logic [COORD_W-1:0] SRC_Y_C   = COORD_W'(SRC_Y);
  localparam logic [LEN_W-1:0]   MAX_LEN_C = LEN_W'(MAX_LEN);

  pkt_state_e         state;
  logic [COORD_W-1:0] dst_x_q;
  logic [COORD_W-1:0] dst_y_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   remaining;
  logic               cmd_ready_q;
  logic               err_len_q;

  logic               slot_free;
  logic               load;
  logic [FLIT_W-1:0]  load_flit;
  logic               cmd_hs;
  logic               len_over;
  logic [LEN_W-1:0]   len_eff;
  logic               last_word;
  flit_type_e         head_type;
  flit_type_e         body_type;
  logic [FLIT_W-1:0]  head_flit;

  assign cmd_ready  = cmd_ready_q;
  assign err_len    = err_len_q;
  assign data_ready = (state == PKT_BODY) && slot_free;

  assign cmd_hs    = cmd_valid && cmd_ready_q;
  assign len_over  = cmd_len > MAX_LEN_C;
  assign len_eff   = len_over ? MAX_LEN_C : cmd_len;
  assign last_word = remaining == LEN_W'(1);
  assign head_type = (len_q == '0) ? FLIT_SINGLE : FLIT_HEAD;
  assign body_type = last_word ? FLIT_TAIL : FLIT_BODY;
  assign head_flit = {head_type, dst_x_q, dst_y_q, SRC_X_C, SRC_Y_C, len_q,
                      {PAD_W{1'b0}}};

  // Flit selection: head in HEAD, payload words in BODY, only into a free slot.
  always_comb begin
    load      = 1'b0;
    load_flit = '0;
    case (state)
      PKT_HEAD: begin
        if (slot_free) begin
          load      = 1'b1;
          load_flit = head_flit;
        end
      end
      PKT_BODY: begin
        if (data_valid && slot_free) begin
          load      = 1'b1;
          load_flit = {body_type, data_word};
        end
      end
      default: ;
    endcase
  end

  // Packet FSM. cmd_ready is registered so it is 0 during reset and rises
  // one cycle after reset is released, and again on every return to IDLE.
  always_ff @(posedge noc_clk) begin
    if (noc_rst) begin
      state       <= PKT_IDLE;
      cmd_ready_q <= 1'b0;
      err_len_q   <= 1'b0;
      dst_x_q     <= '0;
      dst_y_q     <= '0;
      len_q       <= '0;
      remaining   <= '0;
    end else begin
      err_len_q <= 1'b0;
      case (state)
        PKT_IDLE: begin
          cmd_ready_q <= !cmd_hs;
          if (cmd_hs) begin
            dst_x_q   <= cmd_dst_x;
            dst_y_q   <= cmd_dst_y;
            len_q     <= len_eff;
            remaining <= len_eff;
            err_len_q <= len_over;
            state     <= PKT_HEAD;
          end
        end
        PKT_HEAD: begin
          if (slot_free) begin
            if (len_q == '0) begin
              state       <= PKT_IDLE;
              cmd_ready_q <= 1'b1;
            end else begin
              state <= PKT_BODY;
            end
          end
        end
        PKT_BODY: begin
          if (load) begin
            remaining <= remaining - LEN_W'(1);
            if (last_word) begin
              state       <= PKT_IDLE;
              cmd_ready_q <= 1'b1;
            end
          end
        end
        default: begin
          state       <= PKT_IDLE;
          cmd_ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Output register stage.
  noc_flit_out_reg #(
    .FLIT_W (FLIT_W)
  ) u_out_reg (
    .clk       (noc_clk),
    .rst       (noc_rst),
    .load      (load),
    .load_flit (load_flit),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_flit  (out_flit),
    .slot_free (slot_free)
  );

`ifdef NOC_PKT_STATS_EN
  logic       out_hs;
  flit_type_e out_type;

  assign out_hs   = out_valid && out_ready;
  assign out_type = flit_type_e'(out_flit[FLIT_W-1:FLIT_W-2]);

  always_ff @(posedge noc_clk) begin
    if (noc_rst) begin
      pkt_count  <= '0;
      flit_count <= '0;
    end else if (out_hs) begin
      flit_count <= flit_count + 32'd1;
      if (out_type == FLIT_TAIL || out_type == FLIT_SINGLE) begin
        pkt_count <= pkt_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_noc_local_packetizer.sv
module tb_noc_local_packetizer;
  import Noc_parameters::*;

  localparam int FLIT_W  = 64;
  localparam int COORD_W = 4;
  localparam int MAX_LEN = 16;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);
  localparam int SRC_X   = 1;
  localparam int SRC_Y   = 2;

  typedef struct packed {
    logic [COORD_W-1:0] dx;
    logic [COORD_W-1:0] dy;
    logic [LEN_W-1:0]   len;
  } cmd_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [COORD_W-1:0] cmd_dst_x;
  logic [COORD_W-1:0] cmd_dst_y;
  logic [LEN_W-1:0]   cmd_len;
  logic               data_valid;
  logic               data_ready;
  logic [FLIT_W-3:0]  data_word;
  logic               out_valid;
  logic               out_ready;
  logic [FLIT_W-1:0]  out_flit;
  logic               err_len;
`ifdef NOC_PKT_STATS_EN
  logic [31:0]        pkt_count;
  logic [31:0]        flit_count;
`endif

  always #5 clk = ~clk;

  noc_local_packetizer #(
    .FLIT_W (FLIT_W), .COORD_W (COORD_W), .MAX_LEN (MAX_LEN),
    .SRC_X (SRC_X), .SRC_Y (SRC_Y)
  ) dut (
    .noc_clk    (clk),
    .noc_rst    (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_dst_x  (cmd_dst_x),
    .cmd_dst_y  (cmd_dst_y),
    .cmd_len    (cmd_len),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .data_word  (data_word),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_flit   (out_flit),
    .err_len    (err_len)
`ifdef NOC_PKT_STATS_EN
    ,
    .pkt_count  (pkt_count),
    .flit_count (flit_count)
`endif
  );

  logic [FLIT_W-1:0] exp_q[$];
  logic [FLIT_W-3:0] feed_q[$];
  cmd_t              cmd_q[$];
  int                head_hs[$];
  int                tail_hs[$];
  int                acc_q[$];
  int                n_chk = 0;
  int                n_fail = 0;
  int                cyc = 0;
  int                err_cnt = 0;
  int                pkt_flits = 0;
  int                exp_pkts = 0;
  int                exp_flits = 0;
  bit                feed_en = 1'b1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [FLIT_W-1:0] mk_head(input logic [1:0] ty, input int dx,
                                                input int dy, input int len);
    head_fields_t h;
    h.dst_x = 4'(dx);
    h.dst_y = 4'(dy);
    h.src_x = 4'(SRC_X);
    h.src_y = 4'(SRC_Y);
    h.len   = 5'(len);
    return {ty, h, 41'b0};
  endfunction

  // Queue one packet: command, payload words and the flits it must produce.
  task automatic queue_pkt(input int dx, input int dy, input int len);
    int                eff;
    logic [FLIT_W-3:0] w;
    cmd_t              c;
    eff = (len > MAX_LEN) ? MAX_LEN : len;
    c.dx = COORD_W'(dx);
    c.dy = COORD_W'(dy);
    c.len = LEN_W'(len);
    cmd_q.push_back(c);
    exp_q.push_back(mk_head((eff == 0) ? 2'b11 : 2'b00, dx, dy, eff));
    for (int i = 1; i <= eff; i++) begin
      w = 62'({$urandom(), $urandom()});
      feed_q.push_back(w);
      exp_q.push_back({(i == eff) ? 2'b10 : 2'b01, w});
    end
  endtask

  // One clock: drive inputs, sample mid-cycle, score flits, advance the edge.
  task automatic cycle();
    bit c_hs, d_hs, o_hs;
    logic [FLIT_W-1:0] e;
    if (cmd_q.size() > 0) begin
      cmd_valid = 1'b1;
      cmd_dst_x = cmd_q[0].dx;
      cmd_dst_y = cmd_q[0].dy;
      cmd_len   = cmd_q[0].len;
    end else begin
      cmd_valid = 1'b0;
    end
    if (feed_en && feed_q.size() > 0) begin
      data_valid = 1'b1;
      data_word  = feed_q[0];
    end else begin
      data_valid = 1'b0;
      data_word  = '0;
    end
    #3;
    c_hs = !rst && cmd_valid && cmd_ready;
    d_hs = !rst && data_valid && data_ready;
    o_hs = !rst && out_valid && out_ready;
    if (!rst && err_len) err_cnt++;
    if (o_hs) begin
      n_chk++;
      assert (exp_q.size() > 0) else begin
        n_fail++;
        $error("FAIL sb_unexpected: observed flit %h expected none", out_flit);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_flit", out_flit, e);
        if (e[63:62] == 2'b00 || e[63:62] == 2'b11) head_hs.push_back(cyc + 1);
        if (e[63:62] == 2'b10 || e[63:62] == 2'b11) begin
          tail_hs.push_back(cyc + 1);
          exp_pkts++;
        end
      end
      exp_flits++;
      pkt_flits++;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (c_hs) begin
      cmd_q.delete(0);
      acc_q.push_back(cyc);
    end
    if (d_hs) feed_q.delete(0);
  endtask

  task automatic wait_acc();
    int n = 0;
    while (cmd_q.size() > 0 && n < 20) begin
      cycle();
      n++;
    end
    check("cmd_accept_timeout", 64'(cmd_q.size()), 64'd0);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      cycle();
      n++;
    end
    check("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_stats();
`ifdef NOC_PKT_STATS_EN
    check("pkt_count", 64'(pkt_count), 64'(exp_pkts));
    check("flit_count", 64'(flit_count), 64'(exp_flits));
`endif
  endtask

  task automatic clear_marks();
    head_hs.delete();
    tail_hs.delete();
    acc_q.delete();
    pkt_flits = 0;
    err_cnt   = 0;
  endtask

  initial begin
    logic [FLIT_W-1:0] held;
    int                n;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_dst_x = '0; cmd_dst_y = '0; cmd_len = '0;
    data_valid = 1'b0; data_word = '0; out_ready = 1'b1;
    @(posedge clk);
    #1;
    repeat (3) cycle();

    // Reset state
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_flit", out_flit, 64'd0);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_data_ready", 64'(data_ready), 64'd0);
    check("rst_err_len", 64'(err_len), 64'd0);
    check_stats();
    rst = 1'b0;
    cycle();
    check("cmd_ready_after_rst", 64'(cmd_ready), 64'd1);

    // Zero-length packet: one SINGLE flit, head one edge after acceptance
    clear_marks();
    queue_pkt(2, 3, 0);
    wait_acc();
    check("single_not_yet", 64'(out_valid), 64'd0);
    cycle();
    check("single_valid", 64'(out_valid), 64'd1);
    check("single_flit", out_flit, {2'b11, 4'd2, 4'd3, 4'd1, 4'd2, 5'd0, 41'd0});
    check("single_cmd_ready", 64'(cmd_ready), 64'd1);
    drain();
    check("single_latency", 64'(head_hs[0] - acc_q[0]), 64'd2);
    check("single_pkt_flits", 64'(pkt_flits), 64'd1);
    check_stats();

    // len 3: four flits on consecutive cycles
    clear_marks();
    queue_pkt(5, 6, 3);
    drain();
    check("len3_flits", 64'(pkt_flits), 64'd4);
    check("len3_span", 64'(tail_hs[0] - head_hs[0]), 64'd3);
    check("len3_latency", 64'(head_hs[0] - acc_q[0]), 64'd2);
    check("len3_no_err", 64'(err_cnt), 64'd0);
    check_stats();

    // len 2 with out_ready low on the head: flit stable, no data consumed
    clear_marks();
    out_ready = 1'b0;
    queue_pkt(1, 1, 2);
    wait_acc();
    cycle();
    check("stall_valid", 64'(out_valid), 64'd1);
    check("stall_head", out_flit, exp_q[0]);
    held = out_flit;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("stall_flit_stable", out_flit, held);
      check("stall_data_ready", 64'(data_ready), 64'd0);
      check("stall_feed", 64'(feed_q.size()), 64'd2);
    end
    out_ready = 1'b1;
    drain();
    check("stall_flits", 64'(pkt_flits), 64'd3);

    // Data starvation: bubble inside the packet, then it completes
    clear_marks();
    feed_en = 1'b0;
    queue_pkt(3, 2, 2);
    wait_acc();
    repeat (4) cycle();
    check("starve_bubble", 64'(out_valid), 64'd0);
    check("starve_pending", 64'(exp_q.size()), 64'd2);
    feed_en = 1'b1;
    drain();
    check("starve_flits", 64'(pkt_flits), 64'd3);

    // Over-long command is clamped to MAX_LEN with a single err_len pulse
    clear_marks();
    queue_pkt(7, 8, 20);
    wait_acc();
    check("clamp_err_pulse", 64'(err_len), 64'd1);
    cycle();
    check("clamp_err_clear", 64'(err_len), 64'd0);
    drain();
    check("clamp_err_count", 64'(err_cnt), 64'd1);
    check("clamp_flits", 64'(pkt_flits), 64'd17);
    check_stats();

    // Reset after the 2nd flit of a len-4 packet
    clear_marks();
    queue_pkt(4, 4, 4);
    n = 0;
    while (pkt_flits < 2 && n < 50) begin
      cycle();
      n++;
    end
    check("mid_rst_reached", 64'(pkt_flits), 64'd2);
    rst = 1'b1;
    cycle();
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("mid_rst_data_ready", 64'(data_ready), 64'd0);
    check("mid_rst_out_flit", out_flit, 64'd0);
    exp_q.delete();
    feed_q.delete();
    cmd_q.delete();
    exp_pkts  = 0;
    exp_flits = 0;
    check_stats();
    rst = 1'b0;
    cycle();
    check("mid_rst_idle", 64'(cmd_ready), 64'd1);
    clear_marks();
    queue_pkt(9, 10, 2);
    drain();
    check("post_rst_flits", 64'(pkt_flits), 64'd3);

    // Back-to-back len-1 packets
    clear_marks();
    queue_pkt(4, 5, 1);
    queue_pkt(6, 7, 1);
    drain();
    check("b2b_accept_gap", 64'(acc_q[1] - acc_q[0]), 64'd3);
    check("b2b_head_gap", 64'(head_hs[1] - tail_hs[0]), 64'd2);
    check("b2b_flits", 64'(pkt_flits), 64'd4);
    check_stats();

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
